snn_frame_ctrl: RTL

Top-level sequencer for one SNN inference frame. It unpacks 98 received UART bytes LSB-first into the 784x1 input RAM, owns the RAM address/write mux and hands it to snn_core for the run. It then issues the core start, captures the classified digit and launches a single ASCII result byte on uart_tx. It adds an inter-byte timeout to resynchronise partial frames and counts bytes dropped while busy.

---
 rtl/snn_frame_ctrl_if.sv | 37 +++
 rtl/snn_frame_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/snn_frame_ctrl_if.sv
// snn_frame_ctrl_if: frame sequencer signal bundle.
// Ports: rx byte in, input-RAM write/mux, core start/done, tx launch, status.
interface snn_frame_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic [ADDR_W-1:0] core_addr;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;
  logic              busy;
  logic              timeout;
  logic [7:0]        drop_cnt;

  modport master (
    input  rx_rdy, rx_data, core_addr,
    input  core_done, core_digit, tx_rdy,
    output ram_we, ram_addr, ram_wdata,
    output core_start, tx_start, tx_data,
    output busy, timeout, drop_cnt
  );

  modport slave (
    output rx_rdy, rx_data, core_addr,
    output core_done, core_digit, tx_rdy,
    input  ram_we, ram_addr, ram_wdata,
    input  core_start, tx_start, tx_data,
    input  busy, timeout, drop_cnt
  );
endinterface

// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: one SNN inference frame, rx bytes -> RAM -> core -> tx.
// Ports: clk, rst (sync, active-high), bus (snn_frame_ctrl_if.master).
module snn_frame_ctrl #(
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT   = 5000000
) (
  input logic              clk,
  input logic              rst,
  snn_frame_ctrl_if.master bus
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, UNPACK, WAIT_BYTE, START, RUN, SEND, WAIT_TX
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [2:0]        bit_cnt;
  logic [TMR_W-1:0]  timer;
  logic [7:0]        shreg;
  logic [3:0]        digit_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        drop_q;
  logic [1:0]        guard;
  logic              timeout_q;
  logic              tx_go;
  logic              drop;
  logic              last_byte;
  logic              tmr_exp;

  assign last_byte = byte_cnt == CNT_W'(NUM_BYTES - 1);
  assign tmr_exp   = timer == TMR_W'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    tx_go   = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE:
        if (bus.rx_rdy) state_d = UNPACK;
      UNPACK: begin
        drop = bus.rx_rdy;
        if (bit_cnt == 3'd7)
          state_d = last_byte ? START : WAIT_BYTE;
      end
      WAIT_BYTE:
        // a byte arriving on the expiry cycle still wins
        if (bus.rx_rdy)   state_d = UNPACK;
        else if (tmr_exp) state_d = IDLE;
      START: begin
        drop    = bus.rx_rdy;
        state_d = RUN;
      end
      RUN: begin
        drop = bus.rx_rdy;
        if (bus.core_done) state_d = SEND;
      end
      SEND: begin
        drop = bus.rx_rdy;
        if (bus.tx_rdy) begin
          tx_go   = 1'b1;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        drop = bus.rx_rdy;
        // uart_tx needs a couple of cycles to drop tx_rdy
        if (guard == 2'd2 && bus.tx_rdy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr   <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      shreg     <= '0;
      digit_q   <= '0;
      tx_data_q <= '0;
      drop_q    <= '0;
      guard     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (drop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      unique case (state)
        IDLE:
          if (bus.rx_rdy) begin
            shreg   <= bus.rx_data;
            bit_cnt <= '0;
          end
        UNPACK: begin
          shreg   <= shreg >> 1;
          wr_addr <= wr_addr + ADDR_W'(1);
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            timer    <= '0;
          end
        end
        WAIT_BYTE:
          if (bus.rx_rdy) begin
            shreg   <= bus.rx_data;
            bit_cnt <= '0;
            timer   <= '0;
          end else if (tmr_exp) begin
            timeout_q <= 1'b1;
            wr_addr   <= '0;
            byte_cnt  <= '0;
            timer     <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        START: begin
          wr_addr  <= '0;
          byte_cnt <= '0;
        end
        RUN:
          // load tx_data early so it is stable under tx_start
          if (bus.core_done) begin
            digit_q   <= bus.core_digit;
            tx_data_q <= 8'h30 | {4'h0, bus.core_digit};
          end
        SEND: begin
          guard <= '0;
          if (bus.tx_rdy)
            tx_data_q <= 8'h30 | {4'h0, digit_q};
        end
        WAIT_TX:
          if (guard != 2'd2) guard <= guard + 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.ram_we     = state == UNPACK;
  assign bus.ram_addr   = (state == RUN) ? bus.core_addr : wr_addr;
  assign bus.ram_wdata  = shreg[0];
  assign bus.core_start = state == START;
  assign bus.tx_start   = tx_go;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = state != IDLE;
  assign bus.timeout    = timeout_q;
  assign bus.drop_cnt   = drop_q;
endmodule
